fetch_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit_instr_fields.sv | 19 +
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants: opcodes, NOP encoding, reset PC and instruction field positions.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready handshake between fetch and the memory.
interface fetch_unit_if #(parameter int XLEN = 32);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic [XLEN-1:0] rdata;

    modport master (output req, addr, input ready, rdata);
    modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_unit_instr_fields.sv
// Combinational RV32I field slicer; shared with the decode stage.
module instr_fields
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);
    assign opcode = instr[OPCODE_LSB +: 7];
    assign rd     = instr[RD_LSB     +: 5];
    assign funct3 = instr[FUNCT3_LSB +: 3];
    assign rs1    = instr[RS1_LSB    +: 5];
    assign rs2    = instr[RS2_LSB    +: 5];
    assign funct7 = instr[FUNCT7_LSB +: 7];
endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, drives the imem handshake, holds the IR and
// handles stall and branch/jump redirects (with squash of an in-flight fetch).
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_unit_if.master     imem,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             instr_valid,
    output logic [XLEN-1:0]  instr,
    output logic [XLEN-1:0]  instr_pc,
    output logic [6:0]       opcode,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic             misaligned
);
    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_VALID = 1'b1;

    logic [0:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_pending;
    logic            squash;
    logic [XLEN-1:0] redir_aligned;

    assign redir_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    // A request in flight cannot be withdrawn, so S_FETCH always requests.
    assign imem.req  = (state == S_FETCH) |
                       ((state == S_VALID) & ~stall & ~redirect_valid);
    assign imem.addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            pc_pending  <= RESET_PC;
            squash      <= 1'b0;
            instr       <= XLEN'(NOP_INSTR);
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            misaligned <= redirect_valid & (redirect_pc[1:0] != 2'b00);
            case (state)
                S_FETCH: begin
                    if (imem.ready) begin
                        if (redirect_valid) begin
                            pc     <= redir_aligned;
                            squash <= 1'b0;
                        end else if (squash) begin
                            // Stale response for the pre-redirect address.
                            pc     <= pc_pending;
                            squash <= 1'b0;
                        end else begin
                            instr       <= imem.rdata;
                            instr_pc    <= pc;
                            pc          <= pc + XLEN'(4);
                            instr_valid <= 1'b1;
                            state       <= S_VALID;
                        end
                    end else if (redirect_valid) begin
                        pc_pending <= redir_aligned;
                        squash     <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        pc          <= redir_aligned;
                        state       <= S_FETCH;
                    end else if (!stall) begin
                        if (imem.ready) begin
                            instr    <= imem.rdata;
                            instr_pc <= pc;
                            pc       <= pc + XLEN'(4);
                        end else begin
                            instr_valid <= 1'b0;
                            state       <= S_FETCH;
                        end
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    instr_fields u_fields (
        .instr  (instr[31:0]),
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Cycle table for fetch_unit: each row's expectation is queued when driven and
// checked at the following negedge; reset cases are hand-written around it.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        rdy_drv = 1'b0;
    logic        instr_valid, misaligned;
    logic [31:0] instr, instr_pc;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h0ABC_0033);
    endfunction

    fetch_unit_if #(.XLEN(32)) imem ();
    assign imem.ready = rdy_drv & imem.req;
    assign imem.rdata = mem_fn(imem.addr);

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .imem(imem),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .misaligned(misaligned)
    );

    typedef struct {
        logic        stall, redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        ivld;
        logic [31:0] ipc;
        logic        mis;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];
    vec_t sb[$];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                                input logic rdy, input logic req, input logic [31:0] addr,
                                input logic iv, input logic [31:0] ipc, input logic mis);
        vec_t v;
        v.stall = s; v.redir = r; v.rpc = rpc; v.rdy = rdy;
        v.req = req; v.addr = addr; v.ivld = iv; v.ipc = ipc; v.mis = mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        //             stall redir rpc           rdy | req addr          ivld ipc           mis
        vecs[0]  = mk(0, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0,         0);
        vecs[1]  = mk(0, 0, 32'h0,         1, 1, 32'h4,         1, 32'h0,         0);
        vecs[2]  = mk(0, 0, 32'h0,         1, 1, 32'h8,         1, 32'h4,         0);
        vecs[3]  = mk(1, 0, 32'h0,         1, 0, 32'hC,         1, 32'h8,         0);
        vecs[4]  = mk(1, 0, 32'h0,         1, 0, 32'hC,         1, 32'h8,         0);
        vecs[5]  = mk(1, 0, 32'h0,         1, 0, 32'hC,         1, 32'h8,         0);
        vecs[6]  = mk(0, 0, 32'h0,         1, 1, 32'hC,         1, 32'h8,         0);
        vecs[7]  = mk(0, 0, 32'h0,         0, 1, 32'h10,        1, 32'hC,         0);
        vecs[8]  = mk(0, 1, 32'h40,        0, 1, 32'h10,        0, 32'hC,         0);
        vecs[9]  = mk(0, 0, 32'h0,         0, 1, 32'h10,        0, 32'hC,         0);
        vecs[10] = mk(0, 0, 32'h0,         1, 1, 32'h10,        0, 32'hC,         0);
        vecs[11] = mk(0, 0, 32'h0,         1, 1, 32'h40,        0, 32'hC,         0);
        vecs[12] = mk(1, 1, 32'h100,       1, 0, 32'h44,        1, 32'h40,        0);
        vecs[13] = mk(1, 0, 32'h0,         0, 1, 32'h100,       0, 32'h40,        0);
        vecs[14] = mk(0, 0, 32'h0,         1, 1, 32'h100,       0, 32'h40,        0);
        vecs[15] = mk(0, 1, 32'h106,       1, 0, 32'h104,       1, 32'h100,       0);
        vecs[16] = mk(0, 0, 32'h0,         1, 1, 32'h104,       0, 32'h100,       1);
        vecs[17] = mk(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h108,       1, 32'h104,       0);
        vecs[18] = mk(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h104,       0);
        vecs[19] = mk(0, 0, 32'h0,         0, 1, 32'h0,         1, 32'hFFFF_FFFC, 0);
        vecs[20] = mk(0, 1, 32'h202,       1, 1, 32'h0,         0, 32'hFFFF_FFFC, 0);
        vecs[21] = mk(0, 0, 32'h0,         1, 1, 32'h200,       0, 32'hFFFF_FFFC, 1);
        vecs[22] = mk(0, 0, 32'h0,         0, 1, 32'h204,       1, 32'h200,       0);
        vecs[23] = mk(0, 0, 32'h0,         0, 1, 32'h204,       0, 32'h200,       0);

        // Reset state while rst_n is held low.
        @(negedge clk);
        chk("rst.ivld", {31'b0, instr_valid}, 32'h0);
        chk("rst.instr", instr, 32'h0000_0013);
        chk("rst.ipc", instr_pc, 32'h0);
        chk("rst.mis", {31'b0, misaligned}, 32'h0);
        chk("rst.req", {31'b0, imem.req}, 32'h1);
        chk("rst.addr", imem.addr, 32'h0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < NV; k++) begin
            stall = vecs[k].stall;
            redirect_valid = vecs[k].redir;
            redirect_pc = vecs[k].rpc;
            rdy_drv = vecs[k].rdy;
            sb.push_back(vecs[k]);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("v%0d.req", k), {31'b0, imem.req}, {31'b0, e.req});
            chk($sformatf("v%0d.addr", k), imem.addr, e.addr);
            chk($sformatf("v%0d.ivld", k), {31'b0, instr_valid}, {31'b0, e.ivld});
            chk($sformatf("v%0d.ipc", k), instr_pc, e.ipc);
            chk($sformatf("v%0d.mis", k), {31'b0, misaligned}, {31'b0, e.mis});
            if (e.ivld) chk($sformatf("v%0d.instr", k), instr, mem_fn(e.ipc));
            if (k == 1) begin
                chk("addi.opcode", {25'b0, opcode}, 32'h13);
                chk("addi.rd", {27'b0, rd}, 32'h1);
                chk("addi.rs1", {27'b0, rs1}, 32'h0);
                chk("addi.funct3", {29'b0, funct3}, 32'h0);
            end
            if (k == 12) begin
                chk("f40.funct7", {25'b0, funct7}, 32'h5);
                chk("f40.rs2", {27'b0, rs2}, 32'hB);
                chk("f40.rs1", {27'b0, rs1}, 32'h18);
            end
            @(posedge clk); #1;
        end

        // Reset dropped mid-wait (pc = 0x204): clears without a clock edge.
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; rdy_drv = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.addr", imem.addr, 32'h0);
        chk("arst.ipc", instr_pc, 32'h0);
        chk("arst.instr", instr, 32'h0000_0013);

        // Get a live instruction, then reset asynchronously while it is valid.
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_drv = 1'b1;
        @(posedge clk); #1;
        chk("pre.ivld", {31'b0, instr_valid}, 32'h1);
        chk("pre.addr", imem.addr, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst2.ivld", {31'b0, instr_valid}, 32'h0);
        chk("arst2.addr", imem.addr, 32'h0);
        chk("arst2.req", {31'b0, imem.req}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
